// File: rtl/if_prefetch.sv
// Instruction prefetch queue: one outstanding fetch, DEPTH-entry queue to decode, redirects flush.
// Latency: response visible one cycle after im_rvalid (same cycle if IF_PREFETCH_BYPASS_EN); fetch stalls when queue full.
module if_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     csrret,
  input  logic                     csrctrl,
  input  logic                     csrrst,
  input  logic [31:0]              ret_pc,
  input  logic [31:0]              isr_pc,
  input  logic [1:0]               BranchCtrl,
  input  logic [31:0]              pc_imm,
  input  logic [31:0]              pc_jr,
  output logic                     im_req,
  output logic [31:0]              im_addr,
  input  logic                     im_ready,
  input  logic                     im_rvalid,
  input  logic [31:0]              im_rdata,
  output logic                     id_valid,
  output logic [31:0]              id_pc,
  output logic [31:0]              id_instr,
  input  logic                     id_ready,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          live_q, live_d;
  entry_t        mem_q [DEPTH];

  logic          redirect;
  logic [31:0]   redir_tgt;
  logic          q_empty;
  logic          rsp_push;
  logic          bypass_hit;
  logic          q_push;
  logic          q_pop;
  entry_t        head;

  always_comb begin
    redirect = csrret | csrctrl | csrrst | (BranchCtrl == 2'b01) | (BranchCtrl == 2'b10);
    if (csrret)                    redir_tgt = ret_pc;
    else if (csrctrl)              redir_tgt = isr_pc;
    else if (csrrst)               redir_tgt = 32'h0000_0000;
    else if (BranchCtrl == 2'b01)  redir_tgt = pc_imm;
    else                           redir_tgt = pc_jr;
  end

  // live_q holds off fetching for the first cycle after reset so outputs stay quiet.
  always_comb begin
    q_empty  = (count_q == '0);
    im_req   = !rst && live_q && (state_q == S_IDLE) && !redirect && (count_q < CW'(DEPTH));
    im_addr  = fetch_pc_q;
    rsp_push = (state_q == S_WAIT) && im_rvalid && !redirect;

    bypass_hit = 1'b0;
`ifdef IF_PREFETCH_BYPASS_EN
    bypass_hit = q_empty && rsp_push;
`endif

    head     = mem_q[rptr_q];
    id_valid = !rst && (!q_empty || bypass_hit);
    id_pc    = '0;
    id_instr = '0;
    if (id_valid) begin
      if (bypass_hit) begin
        id_pc    = req_pc_q;
        id_instr = im_rdata;
      end else begin
        id_pc    = head.pc;
        id_instr = head.instr;
      end
    end

    q_pop   = !q_empty && id_ready;
    q_push  = rsp_push && !(bypass_hit && id_ready);
    q_count = count_q;
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    live_d     = 1'b1;

    unique case (state_q)
      S_IDLE:  if (im_req && im_ready) state_d = S_WAIT;
      S_WAIT:  if (im_rvalid)          state_d = S_IDLE;
               else if (redirect)      state_d = S_DROP;
      S_DROP:  if (im_rvalid)          state_d = S_IDLE;
      default:                         state_d = S_IDLE;
    endcase

    if (im_req && im_ready) begin
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (redirect) begin
      fetch_pc_d = redir_tgt;
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
    end else begin
      if (q_push) wptr_d = wptr_q + PW'(1);
      if (q_pop)  rptr_d = rptr_q + PW'(1);
      count_d = count_q + CW'(q_push) - CW'(q_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      live_q     <= live_d;
    end
  end

  // Storage needs no reset: the head is only presented while count_q is non-zero.
  always_ff @(posedge clk) begin
    if (!rst && q_push) begin
      mem_q[wptr_q] <= '{pc: req_pc_q, instr: im_rdata};
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: directed vectors, corner sequences and a random run against a queue model.
module tb_if_prefetch;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        csrret, csrctrl, csrrst;
  logic [31:0] ret_pc, isr_pc, pc_imm, pc_jr;
  logic [1:0]  BranchCtrl;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ready, im_rvalid;
  logic [31:0] im_rdata;
  logic        id_valid;
  logic [31:0] id_pc, id_instr;
  logic        id_ready;
  logic [2:0]  q_count;

  if_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .csrret(csrret), .csrctrl(csrctrl), .csrrst(csrrst),
    .ret_pc(ret_pc), .isr_pc(isr_pc),
    .BranchCtrl(BranchCtrl), .pc_imm(pc_imm), .pc_jr(pc_jr),
    .im_req(im_req), .im_addr(im_addr), .im_ready(im_ready),
    .im_rvalid(im_rvalid), .im_rdata(im_rdata),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .id_ready(id_ready),
    .q_count(q_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct packed {
    logic        ret;
    logic        ctrl;
    logic        crst;
    logic [1:0]  bc;
    logic        e_req;
    logic [31:0] e_addr;
  } vec_t;

  // Reference: queue contents, fetch address, and whether a response is owed (and whether it is stale).
  ent_t        mq[$];
  logic [31:0] m_pc, m_req_pc;
  bit          m_out, m_stale, m_hold;

  int errors = 0;
  int checks = 0;
  logic [31:0] acc_addrs[$], pop_pcs[$], pop_instrs[$];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return ~a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc     = RESET_PC;
    m_req_pc = RESET_PC;
    m_out    = 0;
    m_stale  = 0;
    m_hold   = 1;
  endtask

  task automatic clear_inputs();
    csrret = 0; csrctrl = 0; csrrst = 0; BranchCtrl = 2'b00;
    im_ready = 0; im_rvalid = 0; im_rdata = '0; id_ready = 0;
  endtask

  // One clock: predict and compare outputs for the current inputs, then advance the model at the edge.
  task automatic tick();
    bit          redir, acc, e_req, e_vld, byp;
    logic [31:0] tgt;
    ent_t        hd;
    redir = csrret | csrctrl | csrrst | (BranchCtrl == 2'b01) | (BranchCtrl == 2'b10);
    tgt   = csrret ? ret_pc : csrctrl ? isr_pc : csrrst ? 32'h0 :
            (BranchCtrl == 2'b01) ? pc_imm : pc_jr;
    acc   = !rst && m_out && !m_stale && im_rvalid && !redir;
    e_req = !rst && !m_hold && !m_out && !redir && (mq.size() < DEPTH);
    byp   = 0;
`ifdef IF_PREFETCH_BYPASS_EN
    byp   = acc && (mq.size() == 0);
`endif
    e_vld = !rst && ((mq.size() > 0) || byp);
    hd    = (mq.size() > 0) ? mq[0] : '{pc: m_req_pc, instr: im_rdata};
    #1;
    chk("im_req", 32'(im_req), 32'(e_req));
    chk("im_addr", im_addr, m_pc);
    chk("id_valid", 32'(id_valid), 32'(e_vld));
    chk("q_count", 32'(q_count), 32'(mq.size()));
    if (e_vld) begin
      chk("id_pc", id_pc, hd.pc);
      chk("id_instr", id_instr, hd.instr);
    end
    if (rst) begin
      chk("rst_id_pc", id_pc, 32'h0);
      chk("rst_id_instr", id_instr, 32'h0);
    end else begin
      if (im_req && im_ready) acc_addrs.push_back(im_addr);
      if (id_valid && id_ready) begin
        pop_pcs.push_back(id_pc);
        pop_instrs.push_back(id_instr);
      end
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_hold = 0;
      if (e_vld && id_ready && mq.size() > 0) void'(mq.pop_front());
      if (acc && !(byp && id_ready)) mq.push_back('{pc: m_req_pc, instr: im_rdata});
      if (m_out) begin
        if (im_rvalid) begin m_out = 0; m_stale = 0; end
        else if (redir) m_stale = 1;
      end
      if (e_req && im_ready) begin
        m_out = 1; m_stale = 0; m_req_pc = m_pc; m_pc = m_pc + 32'd4;
      end
      if (redir) begin
        mq.delete();
        m_pc = tgt;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    @(posedge clk); #1;
    model_reset();
    tick();
    rst = 0;
  endtask

  vec_t vecs[8];

  initial begin
    ret_pc = 32'h200; isr_pc = 32'h300; pc_imm = 32'h100; pc_jr = 32'h400;
    vecs[0] = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h200};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h200};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h300};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 32'h100};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h400};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 32'h400};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'h400};

    // Sequential streaming with an always-ready decoder.
    do_reset();
    acc_addrs.delete(); pop_pcs.delete(); pop_instrs.delete();
    im_ready = 1; id_ready = 1;
    repeat (12) begin
      im_rvalid = m_out;
      im_rdata  = instr_of(m_req_pc);
      tick();
    end
    chk("seq_acc_len", 32'(acc_addrs.size() >= 3), 32'd1);
    chk("seq_pop_len", 32'(pop_pcs.size() >= 3), 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (i < acc_addrs.size()) chk("seq_im_addr", acc_addrs[i], 32'(4 * i));
      if (i < pop_pcs.size()) begin
        chk("seq_id_pc", pop_pcs[i], 32'(4 * i));
        chk("seq_id_instr", pop_instrs[i], instr_of(32'(4 * i)));
      end
    end

    // Stalled decoder: queue fills to DEPTH and fetching stops until a pop.
    do_reset();
    acc_addrs.delete();
    im_ready = 1; id_ready = 0;
    repeat (14) begin
      im_rvalid = m_out;
      im_rdata  = instr_of(m_req_pc);
      tick();
    end
    im_rvalid = 0;
    #1;
    chk("full_accepts", 32'(acc_addrs.size()), 32'd4);
    chk("full_q_count", 32'(q_count), 32'd4);
    chk("full_no_req", 32'(im_req), 32'd0);
    id_ready = 1;
    tick();
    id_ready = 0;
    #1;
    chk("full_req_after_pop", 32'(im_req), 32'd1);
    tick();

    // Branch while a fetch is outstanding: stale response dropped.
    do_reset();
    pc_imm = 32'h100;
    im_ready = 1; id_ready = 1;
    tick();
    tick();
    BranchCtrl = 2'b01;
    tick();
    BranchCtrl = 2'b00;
    im_rvalid = 1; im_rdata = 32'hDEAD_BEEF;
    #1;
    chk("drop_no_req", 32'(im_req), 32'd0);
    tick();
    im_rvalid = 0;
    pop_pcs.delete(); pop_instrs.delete();
    #1;
    chk("drop_next_addr", im_addr, 32'h100);
    chk("drop_next_req", 32'(im_req), 32'd1);
    tick();
    im_ready = 0;
    im_rvalid = 1; im_rdata = instr_of(32'h100);
    tick();
    im_rvalid = 0;
    tick();
    tick();
    chk("drop_pop_len", 32'(pop_pcs.size() >= 1), 32'd1);
    if (pop_pcs.size() >= 1) begin
      chk("drop_first_pc", pop_pcs[0], 32'h100);
      chk("drop_first_instr", pop_instrs[0], instr_of(32'h100));
    end

    // Redirect priority table.
    do_reset();
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      csrret = vecs[i].ret; csrctrl = vecs[i].ctrl; csrrst = vecs[i].crst;
      BranchCtrl = vecs[i].bc;
      #1;
      chk("vec_req", 32'(im_req), 32'(vecs[i].e_req));
      tick();
      csrret = 0; csrctrl = 0; csrrst = 0; BranchCtrl = 2'b00;
      #1;
      chk("vec_addr", im_addr, vecs[i].e_addr);
    end

    // Fetch address wraps past the top of the address space.
    pc_jr = 32'hFFFF_FFFC; BranchCtrl = 2'b10;
    tick();
    BranchCtrl = 2'b00; im_ready = 1;
    #1;
    chk("wrap_top_addr", im_addr, 32'hFFFF_FFFC);
    tick();
    im_ready = 0; im_rvalid = 1; im_rdata = 32'hA5A5_5A5A;
    tick();
    im_rvalid = 0;
    #1;
    chk("wrap_next_addr", im_addr, 32'h0);
    tick();

    // Response timing into an empty queue.
    do_reset();
    im_ready = 1; id_ready = 1;
    tick();
    tick();
    im_ready = 0; im_rvalid = 1; im_rdata = 32'h1234_5678;
    #1;
`ifdef IF_PREFETCH_BYPASS_EN
    chk("byp_same_vld", 32'(id_valid), 32'd1);
    chk("byp_same_instr", id_instr, 32'h1234_5678);
`else
    chk("nobyp_same_vld", 32'(id_valid), 32'd0);
`endif
    tick();
    im_rvalid = 0;
    #1;
`ifdef IF_PREFETCH_BYPASS_EN
    chk("byp_q_count", 32'(q_count), 32'd0);
    chk("byp_next_vld", 32'(id_valid), 32'd0);
`else
    chk("nobyp_next_vld", 32'(id_valid), 32'd1);
    chk("nobyp_next_pc", id_pc, 32'h0);
    chk("nobyp_next_instr", id_instr, 32'h1234_5678);
`endif
    tick();

    // Random traffic, redirects and occasional resets against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 15);
      rst        = ($urandom_range(0, 299) == 0);
      csrret     = (r == 0);
      csrctrl    = (r == 1) || (r == 0 && $urandom_range(0, 1) == 1);
      csrrst     = (r == 2) || (r == 1 && $urandom_range(0, 1) == 1);
      BranchCtrl = (r == 3) ? 2'b01 : (r == 4) ? 2'b10 :
                   ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
      ret_pc     = $urandom; isr_pc = $urandom; pc_imm = $urandom; pc_jr = $urandom;
      im_ready   = ($urandom_range(0, 3) != 0);
      id_ready   = ($urandom_range(0, 2) != 0);
      im_rvalid  = m_out ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
      im_rdata   = $urandom;
      tick();
    end
    rst = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
